// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared opcodes, ALUop encodings and control-bundle bit layout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i_alu  = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [31:0] c_nop      = 32'h0000_0013;

  localparam logic [1:0] c_aluop_add    = 2'b00;
  localparam logic [1:0] c_aluop_branch = 2'b01;
  localparam logic [1:0] c_aluop_funct  = 2'b10;

  // Single ordering of the control bundle shared with the decode control unit.
  localparam int c_ctrl_w          = 8;
  localparam int c_bit_branch      = 0;
  localparam int c_bit_memread     = 1;
  localparam int c_bit_memtoreg    = 2;
  localparam int c_bit_memwrite    = 3;
  localparam int c_bit_regwrite    = 4;
  localparam int c_bit_alusrc      = 5;
  localparam int c_bit_aluop_lo    = 6;
  localparam int c_bit_aluop_hi    = 7;

  function automatic logic [c_ctrl_w-1:0] pack_ctrl(
    input logic       branch,
    input logic       memread,
    input logic       memtoreg,
    input logic       memwrite,
    input logic       regwrite,
    input logic       alusrc,
    input logic [1:0] aluop
  );
    logic [c_ctrl_w-1:0] v;
    v                                 = '0;
    v[c_bit_branch]                   = branch;
    v[c_bit_memread]                  = memread;
    v[c_bit_memtoreg]                 = memtoreg;
    v[c_bit_memwrite]                 = memwrite;
    v[c_bit_regwrite]                 = regwrite;
    v[c_bit_alusrc]                   = alusrc;
    v[c_bit_aluop_hi:c_bit_aluop_lo]  = aluop;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detection_unit.sv
// ============================================================================
// Module   : hazard_detection_unit
// Purpose  : Combinational load-use detector; a taken branch suppresses stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detection_unit
  import riscv_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       flush,
  output logic       stall,
  output logic       control_sel,
  output logic       pc_write,
  output logic       if_id_write
);

  logic w_rd_match;

  // Both sources are compared regardless of format; x0 never creates a hazard.
  assign w_rd_match  = (ex_rd == id_rs1) | (ex_rd == id_rs2);
  assign stall       = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid
                       & w_rd_match & ~flush;
  assign control_sel = stall;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use stall, flush and counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_b5,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_regwrite,
  input  logic             id_alusrc,
  input  logic [1:0]       id_aluop,
  input  logic             flush,
  output logic             control_sel,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_b5,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_regwrite,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [c_ctrl_w-1:0] w_id_ctrl;
  logic [c_ctrl_w-1:0] r_ex_ctrl;
  logic                w_stall;
  logic                w_bubble;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  hazard_detection_unit u_hazard (
    .ex_valid    (ex_valid),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .stall       (w_stall),
    .control_sel (control_sel),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  assign w_id_ctrl = pack_ctrl(id_branch, id_memread, id_memtoreg, id_memwrite,
                               id_regwrite, id_alusrc, id_aluop);
  assign w_bubble  = flush | w_stall;

  // A bubble zeroes data and indices as well, so EX never sees stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7_b5 <= 1'b0;
      r_ex_ctrl    <= '0;
    end else if (w_bubble) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7_b5 <= 1'b0;
      r_ex_ctrl    <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_funct3    <= id_funct3;
      ex_funct7_b5 <= id_funct7_b5;
      r_ex_ctrl    <= w_id_ctrl;
    end
  end

  assign ex_branch   = r_ex_ctrl[c_bit_branch];
  assign ex_memread  = r_ex_ctrl[c_bit_memread];
  assign ex_memtoreg = r_ex_ctrl[c_bit_memtoreg];
  assign ex_memwrite = r_ex_ctrl[c_bit_memwrite];
  assign ex_regwrite = r_ex_ctrl[c_bit_regwrite];
  assign ex_alusrc   = r_ex_ctrl[c_bit_alusrc];
  assign ex_aluop    = r_ex_ctrl[c_bit_aluop_hi:c_bit_aluop_lo];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush   && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed scoreboard bench for the ID/EX stage (counters at 4 bits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic            branch;
    logic            memread;
    logic            memtoreg;
    logic            memwrite;
    logic            regwrite;
    logic            alusrc;
    logic [1:0]      aluop;
  } ex_t;

  typedef struct {
    ex_t             ex;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    string           tag;
  } exp_t;

  logic clk, rst_n;
  logic id_valid, id_funct7_b5, flush;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic id_branch, id_memread, id_memtoreg, id_memwrite, id_regwrite, id_alusrc;
  logic [1:0] id_aluop;
  logic control_sel, pc_write, if_id_write, ex_valid, ex_funct7_b5;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_regwrite, ex_alusrc;
  logic [1:0] ex_aluop;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t sb[$];
  ex_t m_ex;
  logic [CNT_W-1:0] m_sc, m_fc;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .id_branch(id_branch), .id_memread(id_memread),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_regwrite(id_regwrite),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop), .flush(flush),
    .control_sel(control_sel), .pc_write(pc_write), .if_id_write(if_id_write),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7_b5(ex_funct7_b5),
    .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc),
    .ex_aluop(ex_aluop), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic ex_t cur_id();
    ex_t v;
    v = {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
         id_funct3, id_funct7_b5, id_branch, id_memread, id_memtoreg, id_memwrite,
         id_regwrite, id_alusrc, id_aluop};
    return v;
  endfunction

  function automatic ex_t dut_ex();
    ex_t v;
    v = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
         ex_funct3, ex_funct7_b5, ex_branch, ex_memread, ex_memtoreg, ex_memwrite,
         ex_regwrite, ex_alusrc, ex_aluop};
    return v;
  endfunction

  task automatic chk_ex(input ex_t obs, input ex_t exp, input string tag);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [7:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = pc ^ 32'hA5A5_0000; id_rs2_data = pc ^ 32'h0000_5A5A;
    id_imm = pc + 32'd4; id_funct3 = pc[2:0]; id_funct7_b5 = pc[3];
    {id_aluop, id_alusrc, id_regwrite, id_memwrite, id_memtoreg, id_memread, id_branch} = ctrl;
  endtask

  // Called just after an active edge: check hazard outputs, predict, clock, compare.
  task automatic step(input logic exp_stall, input string tag);
    logic m_stall;
    exp_t e;
    #3;
    chk({31'd0, control_sel}, {31'd0, exp_stall}, {tag, ".control_sel"});
    chk({31'd0, pc_write}, {31'd0, ~exp_stall}, {tag, ".pc_write"});
    chk({31'd0, if_id_write}, {31'd0, ~exp_stall}, {tag, ".if_id_write"});
    m_stall = m_ex.valid & m_ex.memread & (m_ex.rd != 5'd0) & id_valid
              & ((m_ex.rd == id_rs1) | (m_ex.rd == id_rs2)) & ~flush;
    m_ex = (flush | m_stall) ? '0 : cur_id();
    if (m_stall && m_sc != 4'hF) m_sc = m_sc + 4'd1;
    if (flush && m_fc != 4'hF) m_fc = m_fc + 4'd1;
    e.ex = m_ex; e.sc = m_sc; e.fc = m_fc; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk_ex(dut_ex(), e.ex, {e.tag, ".ex"});
    chk({28'd0, stall_cnt}, {28'd0, e.sc}, {e.tag, ".stall_cnt"});
    chk({28'd0, flush_cnt}, {28'd0, e.fc}, {e.tag, ".flush_cnt"});
  endtask

  // ctrl = {aluop[1:0], alusrc, regwrite, memwrite, memtoreg, memread, branch}
  localparam logic [7:0] CTRL_R     = 8'b10_0_1_0_0_0_0;
  localparam logic [7:0] CTRL_LOAD  = 8'b00_1_1_0_1_1_0;
  localparam logic [7:0] CTRL_STORE = 8'b00_1_0_1_0_0_0;

  initial begin
    m_ex = '0; m_sc = '0; m_fc = '0;
    rst_n = 1'b0; flush = 1'b0;
    set_id(1'b1, 32'h100, 5'd7, 5'd9, 5'd3, CTRL_LOAD);
    repeat (2) @(posedge clk);
    #1;
    chk_ex(dut_ex(), '0, "reset_hold.ex");
    chk({28'd0, stall_cnt}, 32'd0, "reset_hold.stall_cnt");
    chk({28'd0, flush_cnt}, 32'd0, "reset_hold.flush_cnt");
    rst_n = 1'b1;
    step(1'b0, "first_load");

    // Asynchronous reset pulse between edges, with EX and inputs non-zero.
    flush = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_ex(dut_ex(), '0, "async_reset.ex");
    chk({28'd0, stall_cnt}, 32'd0, "async_reset.stall_cnt");
    chk({28'd0, flush_cnt}, 32'd0, "async_reset.flush_cnt");
    #1 rst_n = 1'b1; flush = 1'b0;
    m_ex = '0; m_sc = '0; m_fc = '0;
    set_id(1'b1, 32'h204, 5'd7, 5'd9, 5'd3, CTRL_LOAD);
    @(posedge clk); #1;
    chk(ex_pc, 32'h204, "post_reset.ex_pc");
    m_ex = cur_id();

    // Pass-through R-type; no hazard against the load of x3 now in EX.
    set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd5, CTRL_R);
    step(1'b0, "rtype");
    chk(ex_pc, 32'h40, "rtype.ex_pc");
    chk({27'd0, ex_rd}, 32'd5, "rtype.ex_rd");
    chk({30'd0, ex_aluop}, 32'd2, "rtype.ex_aluop");

    // Load-use on rs2: one stall cycle, then the add proceeds.
    set_id(1'b1, 32'h44, 5'd1, 5'd0, 5'd6, CTRL_LOAD);
    step(1'b0, "lw_x6");
    set_id(1'b1, 32'h48, 5'd3, 5'd6, 5'd7, CTRL_R);
    step(1'b1, "load_use");
    chk({31'd0, ex_valid}, 32'd0, "load_use.bubble_valid");
    step(1'b0, "load_use_release");
    chk(ex_pc, 32'h48, "load_use_release.ex_pc");
    chk({28'd0, stall_cnt}, 32'd1, "load_use.stall_cnt");

    // No false stall: load to x0, and dependent but invalid ID slot.
    set_id(1'b1, 32'h50, 5'd1, 5'd0, 5'd0, CTRL_LOAD);
    step(1'b0, "lw_x0");
    set_id(1'b1, 32'h54, 5'd0, 5'd0, 5'd4, CTRL_R);
    step(1'b0, "x0_no_stall");
    set_id(1'b1, 32'h58, 5'd1, 5'd0, 5'd8, CTRL_LOAD);
    step(1'b0, "lw_x8");
    set_id(1'b0, 32'h5C, 5'd8, 5'd8, 5'd4, CTRL_R);
    step(1'b0, "invalid_id_no_stall");

    // Flush beats a pending load-use stall.
    set_id(1'b1, 32'h60, 5'd1, 5'd0, 5'd9, CTRL_LOAD);
    step(1'b0, "lw_x9");
    set_id(1'b1, 32'h64, 5'd9, 5'd2, 5'd10, CTRL_R);
    flush = 1'b1;
    step(1'b0, "flush_over_stall");
    flush = 1'b0;
    chk({28'd0, flush_cnt}, 32'd1, "flush_over_stall.flush_cnt");

    // Unknown memtoreg on a store is carried through unchanged.
    set_id(1'b1, 32'h68, 5'd2, 5'd3, 5'd0, CTRL_STORE);
    id_memtoreg = 1'bx;
    step(1'b0, "store_x_memtoreg");

    // lw x6,0(x6) repeatedly: stalls every other cycle, 20 stalls total.
    set_id(1'b1, 32'h70, 5'd6, 5'd0, 5'd6, CTRL_LOAD);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, "sat_load");
      step(1'b1, "sat_stall");
    end
    chk({28'd0, stall_cnt}, 32'd15, "saturate.stall_cnt");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
